// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, pixel format and small helpers for the VRAM path.
// Pure definitions: no state, no timing.
package vga_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int FB_W   = 160;
    localparam int FB_H   = 120;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [R_MSB-R_LSB:0] r;
        logic [G_MSB-G_LSB:0] g;
        logic [B_MSB-B_LSB:0] b;
    } rgb332_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vram_arbiter_wr_fifo.sv
// Synchronous write-buffer FIFO; head visible one cycle after push, no bypass.
// Push is ignored when full and pop is ignored when empty.
module wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rptr];
    assign o_level = r_level;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out reads win every cycle, buffered writes drain in gaps.
// Read data returns 2 cycles after rd_req; writers see wr_ready=0 while the buffer is full.
module vram_arbiter #(
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int DATA_W     = vga_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_we,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   stall_cnt
);

    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0]  w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              r_rd_pend;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [15:0]       r_stall;

    // Readiness ignores a same-cycle pop, so a full buffer never accepts.
    assign wr_ready = !w_full && !RST;
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = !rd_req && !w_empty;

    wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_wr_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_din   ({wr_addr, wr_data}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_level (fifo_level),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = r_addr_hold;
        mem_wdata = '0;
        if (RST) begin
            mem_addr = '0;
        end else if (rd_req) begin
            mem_addr = rd_addr;
        end else if (w_pop) begin
            mem_we    = 1'b1;
            mem_addr  = w_head[ENT_W-1:DATA_W];
            mem_wdata = w_head[DATA_W-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr_hold <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_stall     <= '0;
        end else begin
            r_addr_hold <= mem_addr;
            r_rd_pend   <= rd_req;
            r_rd_valid  <= r_rd_pend;
            if (r_rd_pend) r_rd_data <= mem_rdata;
            if (wr_valid && !wr_ready) r_stall <= vga_pkg::sat_inc16(r_stall);
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign stall_cnt = r_stall;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and scenario stimulus for vram_arbiter against a queue-based transaction model.
module tb_vram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rd_req = 1'b0;
    logic [14:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [14:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [2:0]  fifo_level;
    logic [15:0] stall_cnt;

    always #5 CLK = ~CLK;

    vram_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level),
        .stall_cnt  (stall_cnt)
    );

    // Single-port synchronous BRAM, read-first.
    logic [7:0] bram [0:32767];
    always @(posedge CLK) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [7:0]  ref_mem [0:32767];
    logic [14:0] wq_a [$];
    logic [7:0]  wq_d [$];
    int          rq_due [$];
    logic [7:0]  rq_dat [$];
    logic [15:0] m_stall = '0;
    logic [14:0] last_addr = '0;
    logic        dummy;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        wq_a.delete();
        wq_d.delete();
        rq_due.delete();
        rq_dat.delete();
        m_stall   = '0;
        last_addr = '0;
    endtask

    // One clock of stimulus; the model decides what the DUT must show this cycle.
    task automatic step(input logic rq, input logic [14:0] ra, input logic wv,
                        input logic [14:0] wa, input logic [7:0] wd, output logic acc);
        logic        exp_rdy;
        logic        exp_we;
        logic        exp_v;
        logic [14:0] exp_addr;
        @(negedge CLK);
        rd_req   = rq;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        #1;
        exp_rdy  = (wq_a.size() < 4);
        exp_we   = !rq && (wq_a.size() > 0);
        exp_addr = rq ? ra : (exp_we ? wq_a[0] : last_addr);
        exp_v    = (rq_due.size() > 0) && (rq_due[0] == cyc);
        chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
        chk("fifo_level", 32'(fifo_level), 32'(wq_a.size()));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(wq_d[0]));
        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (exp_v) begin
            chk("rd_data", 32'(rd_data), 32'(rq_dat[0]));
            void'(rq_due.pop_front());
            void'(rq_dat.pop_front());
        end
        if (exp_we) begin
            ref_mem[wq_a[0]] = wq_d[0];
            void'(wq_a.pop_front());
            void'(wq_d.pop_front());
        end
        if (rq) begin
            rq_due.push_back(cyc + 2);
            rq_dat.push_back(ref_mem[ra]);
        end
        acc = wv && exp_rdy;
        if (acc) begin
            wq_a.push_back(wa);
            wq_d.push_back(wd);
        end
        if (wv && !exp_rdy && m_stall != 16'hFFFF) m_stall++;
        if (rq || exp_we) last_addr = exp_addr;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        RST      = 1'b1;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);
        model_reset();
    endtask

    initial begin
        logic [14:0] c_a [6];
        logic [7:0]  c_d [6];
        int          held [$];
        int          n_we;
        logic        acc;

        do_reset();

        // Give every address used below a known value through the DUT itself.
        for (int i = 0; i < 64; i++) step(1'b0, 15'd0, 1'b1, 15'(i), 8'($urandom), dummy);
        repeat (3) step(1'b0, 15'd0, 1'b0, 15'd0, 8'd0, dummy);

        // Write during an idle gap, then read it back.
        step(1'b0, 15'd0, 1'b1, 15'h0010, 8'hA5, dummy);
        step(1'b0, 15'd0, 1'b0, 15'd0, 8'd0, dummy);
        step(1'b1, 15'h0010, 1'b0, 15'd0, 8'd0, dummy);
        step(1'b0, 15'd0, 1'b0, 15'd0, 8'd0, dummy);
        step(1'b0, 15'd0, 1'b0, 15'd0, 8'd0, dummy);
        chk("idle_rd_valid", 32'(rd_valid), 32'd1);
        chk("idle_rd_data", 32'(rd_data), 32'hA5);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 3) != 0, 15'($urandom_range(0, 63)), $urandom_range(0, 9) < 6,
                 15'($urandom_range(0, 63)), 8'($urandom), dummy);
        end

        // Reads hold the port for 10 cycles while six writes arrive.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            c_a[i] = 15'(8'h30 + i);
            c_d[i] = 8'(8'h50 + i);
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                step(1'b1, 15'(i), 1'b1, c_a[i], c_d[i], acc);
                if (!acc) held.push_back(i);
            end else begin
                step(1'b1, 15'(i), 1'b0, 15'd0, 8'd0, acc);
            end
        end
        chk("cont_level", 32'(fifo_level), 32'd4);
        chk("cont_held", 32'(held.size()), 32'd2);

        n_we = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 15'd0, 1'b0, 15'd0, 8'd0, dummy);
            n_we += int'(mem_we);
        end
        chk("drain_we_cycles", 32'(n_we), 32'd4);
        chk("drain_level", 32'(fifo_level), 32'd0);
        foreach (held[k]) step(1'b0, 15'd0, 1'b1, c_a[held[k]], c_d[held[k]], dummy);
        repeat (3) step(1'b0, 15'd0, 1'b0, 15'd0, 8'd0, dummy);
        chk("cont_stall", 32'(stall_cnt), 32'd2);

        // Push and pop together at level 2, then a pop attempt while full.
        step(1'b1, 15'd1, 1'b1, 15'd40, 8'h11, dummy);
        step(1'b1, 15'd2, 1'b1, 15'd41, 8'h22, dummy);
        step(1'b0, 15'd0, 1'b1, 15'd42, 8'h33, dummy);
        step(1'b1, 15'd3, 1'b0, 15'd0, 8'd0, dummy);
        chk("pushpop_level", 32'(fifo_level), 32'd2);
        step(1'b1, 15'd4, 1'b1, 15'd43, 8'h44, dummy);
        step(1'b1, 15'd5, 1'b1, 15'd44, 8'h55, dummy);
        step(1'b0, 15'd0, 1'b1, 15'd45, 8'h66, dummy);
        chk("full_pop_ready", 32'(wr_ready), 32'd0);
        repeat (6) step(1'b0, 15'd0, 1'b0, 15'd0, 8'd0, dummy);

        // Reset with three buffered writes and two reads in flight.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 15'(i), 1'b1, 15'(50 + i), 8'(8'hC0 + i), dummy);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 15'd0, 1'b0, 15'd0, 8'd0, dummy);
            chk("post_rst_we", 32'(mem_we), 32'd0);
        end

        // Stall counter saturation.
        @(negedge CLK);
        rd_req   = 1'b1;
        rd_addr  = 15'd0;
        wr_valid = 1'b1;
        repeat (70000) @(negedge CLK);
        #1;
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        @(negedge CLK);
        #1;
        chk("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, framebuffer address width (160x120 = 19200 pixels).
REQ-002 Parameter DATA_W, default 8, pixel width, RGB332.
REQ-003 Parameter FIFO_DEPTH, default 4, write-buffer entries; power of two, at least 2.
REQ-004 CLK  in  1  pixel clock; sole clock.
REQ-005 RST  in  1  reset; asynchronous, active-high.
REQ-006 rd_req  in  1  scan-out fetch request, one pixel per cycle.
REQ-007 rd_addr  in  ADDR_W  scan-out fetch address, sampled with rd_req.
REQ-008 rd_data  out  DATA_W  fetched pixel, valid when rd_valid=1.
REQ-009 rd_valid  out  1  rd_data qualifier.
REQ-010 wr_valid  in  1  writer request.
REQ-011 wr_ready  out  1  write buffer can accept.
REQ-012 wr_addr  in  ADDR_W  write address.
REQ-013 wr_data  in  DATA_W  write pixel.
REQ-014 mem_addr  out  ADDR_W  single-port sync BRAM address.
REQ-015 mem_wdata  out  DATA_W  BRAM write data.
REQ-016 mem_we  out  1  BRAM write enable.
REQ-017 mem_rdata  in  DATA_W  BRAM read data, valid one cycle after address with mem_we=0.
REQ-018 fifo_level  out  clog2(FIFO_DEPTH)+1  buffered write count.
REQ-019 stall_cnt  out  16  saturating count of cycles with wr_valid=1 and wr_ready=0.

Function
REQ-020 Fixed priority: rd_req=1 in cycle N SHALL drive mem_addr=rd_addr, mem_we=0 in cycle N (combinational); writes never preempt reads.
REQ-021 rd_valid SHALL assert in cycle N+2, with rd_data registered from mem_rdata; fixed 2-cycle latency, back-to-back reads at one per cycle.
REQ-022 If rd_req=0 and the FIFO is non-empty, the FIFO head SHALL drive mem_addr/mem_wdata, mem_we=1, and pop in that cycle.
REQ-023 If rd_req=0 and the FIFO is empty: mem_we=0; mem_addr holds its last value.
REQ-024 wr_ready SHALL be 1 iff fifo_level < FIFO_DEPTH and RST=0; no pop-bypass when full.
REQ-025 Push on wr_valid && wr_ready; push into an empty FIFO commits no earlier than the next cycle (no write bypass).
REQ-026 Simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-027 Writes SHALL commit to memory in acceptance order.
REQ-028 Read-after-write hazard: no forwarding; a read of an address still buffered returns old memory contents.
REQ-029 stall_cnt SHALL saturate at 0xFFFF; it is cleared only by RST.
REQ-030 Read and write pointer arithmetic SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 On RST: rd_valid=0, rd_data=0, mem_we=0, mem_addr=0, mem_wdata=0, fifo_level=0, stall_cnt=0, wr_ready=0.
REQ-032 RST mid-operation SHALL discard buffered writes and in-flight reads; no rd_valid pulse follows reset.
REQ-033 wr_ready SHALL be 1 in the first cycle after RST deasserts.

Structure
REQ-034 Shared package vga_pkg: ADDR_W, DATA_W, FB_W=160, FB_H=120, RGB332 field positions (R[7:5], G[4:2], B[1:0]).
REQ-035 One sub-module, wr_fifo: synchronous FIFO parameterised by FIFO_DEPTH and width ADDR_W+DATA_W, exposing level.

Verification
REQ-036 Idle read: write 0xA5 to 0x0010 during a no-read gap, then rd_req with addr 0x0010 -> rd_valid two cycles later, rd_data=0xA5.
REQ-037 Contention: rd_req held for 10 cycles while the writer pushes 6 writes -> 4 accepted, wr_ready=0 for the rest, stall_cnt=2 after the held writes are accepted, mem_we=0 throughout the read burst.
REQ-038 Drain: release rd_req with 4 writes buffered -> mem_we=1 for exactly 4 consecutive cycles in push order, fifo_level reaching 0.
REQ-039 Simultaneous push and pop with fifo_level=2 -> level stays 2; full FIFO with pop -> wr_ready stays 0 that cycle.
REQ-040 RST asserted with 3 buffered writes and 2 reads in flight -> no mem_we, no rd_valid afterwards; wr_ready=1 one cycle after release.
REQ-041 Saturation: force 70000 stall cycles -> stall_cnt=0xFFFF.
